// File: rtl/op_byte_driver.sv
// Byte-stream front end for an N-bit two-operand operation. It gathers lhs and rhs
// bytes (LSB first), drives the operation, waits out its latency, and returns the result bytes.
module op_byte_driver #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int RESULT_LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [OPERAND_WIDTH-1:0] op_lhs,
  output logic [OPERAND_WIDTH-1:0] op_rhs,
  input  logic [OPERAND_WIDTH-1:0] op_result,
  output logic                     busy
);
  localparam int BYTES = (OPERAND_WIDTH + 7) / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LAT_W = (RESULT_LATENCY > 0) ? $clog2(RESULT_LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RESULT_LATENCY);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RX_LHS = 3'd1;
  localparam logic [2:0] ST_RX_RHS = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_TX     = 3'd4;

  logic [2:0]               state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [LAT_W-1:0]         lat_reg, lat_next;
  logic [OPERAND_WIDTH-1:0] lhs_shadow_reg, lhs_shadow_next;
  logic [OPERAND_WIDTH-1:0] rhs_shadow_reg, rhs_shadow_next;
  logic [OPERAND_WIDTH-1:0] op_lhs_reg, op_rhs_reg;
  logic [OPERAND_WIDTH-1:0] result_reg;
  logic [7:0]               result_bytes [BYTES];
  logic [BYTES-1:0]         lane_sel;
  logic                     rx_fire, tx_fire, last_byte, eval_done, load_ops;

  assign rx_ready  = (state_reg == ST_RX_LHS) || (state_reg == ST_RX_RHS);
  assign tx_valid  = (state_reg == ST_TX);
  assign busy      = !((state_reg == ST_RX_LHS) && (idx_reg == '0));
  assign rx_fire   = rx_valid && rx_ready && !flush;
  assign tx_fire   = tx_valid && tx_ready && !flush;
  assign last_byte = (idx_reg == LAST_IDX);
  assign eval_done = (state_reg == ST_EVAL) && (lat_reg == LAST_LAT);
  assign load_ops  = rx_fire && (state_reg == ST_RX_RHS) && last_byte;
  assign op_lhs    = op_lhs_reg;
  assign op_rhs    = op_rhs_reg;
  assign tx_data   = tx_valid ? result_bytes[idx_reg] : 8'h00;

  // Per-byte lanes; the top lane is narrowed so bits above OPERAND_WIDTH are never stored or sent.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      localparam int LW = ((OPERAND_WIDTH - 8 * gi) >= 8) ? 8 : (OPERAND_WIDTH - 8 * gi);
      assign lane_sel[gi] = rx_fire && (idx_reg == IDX_W'(gi));
      assign lhs_shadow_next[8*gi +: LW] = (lane_sel[gi] && (state_reg == ST_RX_LHS)) ?
                                           rx_data[LW-1:0] : lhs_shadow_reg[8*gi +: LW];
      assign rhs_shadow_next[8*gi +: LW] = (lane_sel[gi] && (state_reg == ST_RX_RHS)) ?
                                           rx_data[LW-1:0] : rhs_shadow_reg[8*gi +: LW];
      assign result_bytes[gi] = 8'(result_reg[8*gi +: LW]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lat_next   = lat_reg;
    if (flush) begin
      state_next = ST_RX_LHS;
      idx_next   = '0;
      lat_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_RX_LHS;
        ST_RX_LHS, ST_RX_RHS: begin
          if (rx_fire) begin
            if (last_byte) begin
              idx_next   = '0;
              state_next = (state_reg == ST_RX_LHS) ? ST_RX_RHS : ST_EVAL;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
        ST_EVAL: begin
          if (eval_done) begin
            lat_next   = '0;
            state_next = ST_TX;
          end else begin
            lat_next = lat_reg + 1'b1;
          end
        end
        ST_TX: begin
          if (tx_fire) begin
            if (last_byte) begin
              idx_next   = '0;
              state_next = ST_RX_LHS;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // rhs_shadow_next already holds the final byte, so the operands load on that same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      lat_reg        <= '0;
      lhs_shadow_reg <= '0;
      rhs_shadow_reg <= '0;
      op_lhs_reg     <= '0;
      op_rhs_reg     <= '0;
      result_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      lat_reg        <= lat_next;
      lhs_shadow_reg <= lhs_shadow_next;
      rhs_shadow_reg <= rhs_shadow_next;
      if (load_ops) begin
        op_lhs_reg <= lhs_shadow_reg;
        op_rhs_reg <= rhs_shadow_next;
      end
      if (eval_done && !flush) begin
        result_reg <= op_result;
      end
    end
  end

endmodule

// File: tb/tb_op_byte_driver.sv
// Randomised frame bench for op_byte_driver: 12-bit xor operation, one combinational
// instance and one behind a 3-flop result pipeline, checked against a frame-level model.
module tb_op_byte_driver;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        sel;

  logic        rx_ready0, tx_valid0, busy0, rx_ready3, tx_valid3, busy3;
  logic [7:0]  tx_data0, tx_data3;
  logic [11:0] op_lhs0, op_rhs0, op_result0, op_lhs3, op_rhs3, op_result3;
  logic [11:0] pipe1, pipe2, pipe3;

  logic        rx_ready_m, tx_valid_m, busy_m;
  logic [7:0]  tx_data_m;
  logic [11:0] op_lhs_m, op_rhs_m;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] model_lhs, model_rhs;

  op_byte_driver #(.OPERAND_WIDTH(12), .RESULT_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush && !sel),
    .rx_data(rx_data), .rx_valid(rx_valid && !sel), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready && !sel),
    .op_lhs(op_lhs0), .op_rhs(op_rhs0), .op_result(op_result0), .busy(busy0)
  );

  op_byte_driver #(.OPERAND_WIDTH(12), .RESULT_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush && sel),
    .rx_data(rx_data), .rx_valid(rx_valid && sel), .rx_ready(rx_ready3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready && sel),
    .op_lhs(op_lhs3), .op_rhs(op_rhs3), .op_result(op_result3), .busy(busy3)
  );

  assign op_result0 = op_lhs0 ^ op_rhs0;
  assign op_result3 = pipe3;
  always @(posedge clk) begin
    pipe1 <= op_lhs3 ^ op_rhs3;
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end

  assign rx_ready_m = sel ? rx_ready3 : rx_ready0;
  assign tx_valid_m = sel ? tx_valid3 : tx_valid0;
  assign busy_m     = sel ? busy3     : busy0;
  assign tx_data_m  = sel ? tx_data3  : tx_data0;
  assign op_lhs_m   = sel ? op_lhs3   : op_lhs0;
  assign op_rhs_m   = sel ? op_rhs3   : op_rhs0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame semantics: low 12 bits of each LSB-first byte pair; result is lhs xor rhs.
  function automatic logic [11:0] model_res(input logic [31:0] b);
    return b[11:0] ^ b[27:16];
  endfunction

  task automatic send_bytes(input logic [31:0] bytes, input int n, input bit gaps);
    int  i = 0;
    int  t = 0;
    bit  acc;
    while (i < n && t < 400) begin
      rx_data  = bytes[8*i +: 8];
      rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc = rx_valid && rx_ready_m;
      @(negedge clk);
      t++;
      if (acc) i++;
    end
    rx_valid = 1'b0;
    check("rx_bytes_accepted", i, n);
  endtask

  // Entered one cycle after the last rx byte was taken; junk rx traffic must be refused.
  task automatic wait_tx(input int exp_lat);
    int cyc = 1;
    bit bad_rdy = 0;
    while (!tx_valid_m && cyc < 60) begin
      if (rx_ready_m) bad_rdy = 1;
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    check("first_tx_latency", cyc, exp_lat);
    check("rx_ready_in_eval", bad_rdy, 0);
  endtask

  task automatic recv(input logic [7:0] e0, input logic [7:0] e1, input int mode);
    int         j = 0;
    int         t = 0;
    int         stall = 0;
    bit         holding = 0, bad_hold = 0, bad_rdy = 0, acc;
    logic [7:0] held = 8'h00;
    logic [7:0] got [2];
    got[0] = 8'hxx;
    got[1] = 8'hxx;
    while (j < 2 && t < 400) begin
      if (rx_ready_m) bad_rdy = 1;
      if (holding && (!tx_valid_m || tx_data_m !== held)) bad_hold = 1;
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          tx_ready = (stall < 5) ? 1'b0 : 1'b1;
          if (tx_valid_m && stall < 5) stall++;
        end
      endcase
      acc     = tx_valid_m && tx_ready;
      holding = tx_valid_m && !tx_ready;
      held    = tx_data_m;
      if (acc) begin
        got[j] = tx_data_m;
        j++;
      end
      @(negedge clk);
      t++;
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    check("tx_bytes_seen", j, 2);
    check("tx_byte0", got[0], e0);
    check("tx_byte1", got[1], e1);
    check("tx_hold_stable", bad_hold, 0);
    check("rx_ready_in_tx", bad_rdy, 0);
    if (mode == 2) check("stall_cycles", stall, 5);
    check("busy_after_frame", busy_m, 0);
    check("rx_ready_after_frame", rx_ready_m, 1);
  endtask

  task automatic do_frame(input logic [31:0] bytes, input bit gaps, input int mode);
    logic [11:0] res;
    res = model_res(bytes);
    send_bytes(bytes, 4, gaps);
    wait_tx(sel ? 5 : 2);
    check("op_lhs", op_lhs_m, bytes[11:0]);
    check("op_rhs", op_rhs_m, bytes[27:16]);
    recv(res[7:0], {4'h0, res[11:8]}, mode);
    model_lhs = bytes[11:0];
    model_rhs = bytes[27:16];
    $display("frame lat=%0d lhs=0x%03h rhs=0x%03h result=0x%03h mode=%0d",
             sel ? 3 : 0, bytes[11:0], bytes[27:16], res, mode);
  endtask

  initial begin
    logic [11:0] res;
    rst = 1'b1; flush = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; sel = 1'b0;
    model_lhs = '0; model_rhs = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid0, 0);
    check("rst_rx_ready", rx_ready0, 0);
    check("rst_tx_data", tx_data0, 0);
    check("rst_busy", busy0, 1);
    check("rst_op_lhs", op_lhs0, 0);
    check("rst_op_rhs", op_rhs0, 0);
    @(negedge clk);
    rst = 1'b1;
    check("idle_rx_ready", rx_ready0, 0);
    @(negedge clk);
    check("post_idle_rx_ready", rx_ready0, 1);
    check("post_idle_busy", busy0, 0);

    do_frame(32'h0FFF1234, 1'b0, 0);
    do_frame(32'h0FFF1234, 1'b0, 2);
    for (int k = 0; k < 16; k++) do_frame($urandom, 1'b1, 1);

    // flush after three bytes; the byte offered in the flush cycle must be dropped
    send_bytes(32'h00BBCCDD, 3, 1'b0);
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    flush = 1'b0; rx_valid = 1'b0;
    check("flush_busy", busy_m, 0);
    check("flush_rx_ready", rx_ready_m, 1);
    check("flush_op_lhs", op_lhs_m, model_lhs);
    check("flush_op_rhs", op_rhs_m, model_rhs);
    @(negedge clk);
    check("flush_still_idle", busy_m, 0);
    do_frame(32'h00010001, 1'b0, 0);

    sel = 1'b1;
    @(negedge clk);
    do_frame(32'h000F00F0, 1'b0, 0);
    for (int k = 0; k < 4; k++) do_frame($urandom, 1'b1, 1);

    // async reset while the second result byte is waiting
    sel = 1'b0;
    @(negedge clk);
    send_bytes(32'h0ABC0123, 4, 1'b0);
    wait_tx(2);
    res = model_res(32'h0ABC0123);
    tx_ready = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_byte1_pending", tx_data_m, {4'h0, res[11:8]});
    #2 rst = 1'b0;
    #1;
    check("async_tx_valid", tx_valid0, 0);
    check("async_rx_ready", rx_ready0, 0);
    check("async_op_lhs", op_lhs0, 0);
    check("async_op_rhs", op_rhs0, 0);
    check("async_busy", busy0, 1);
    @(negedge clk);
    rst = 1'b1;
    check("reidle_rx_ready", rx_ready0, 0);
    @(negedge clk);
    check("rerun_rx_ready", rx_ready0, 1);
    do_frame($urandom, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_byte_driver.md
Name: op_byte_driver

Overview:
- Sequential, byte-stream-facing driver for the injected side of an N-bit operation interface (lhs, rhs in; result out).
- Collects operand bytes from an upstream byte source (the UART receiver in device test tops), drives lhs/rhs into the operation under test, waits a programmable latency, captures the result, and streams it back out as bytes (to the UART transmitter).
- Used by the on-device unit and integration test tops of every ALU operation core.

Parameters:
- OPERAND_WIDTH, 32, bitwidth of lhs, rhs and result; must be >= 1.
- RESULT_LATENCY, 0, extra cycles the operation needs after operands change before result is valid; 0 means combinational.
- BYTES (localparam), ceil(OPERAND_WIDTH/8), bytes per operand/result on the stream.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort; returns the FSM to RX_LHS
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  driver accepts a byte this cycle
- tx_data  output  8  outgoing result byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  downstream accepts the byte
- op_lhs  output  OPERAND_WIDTH  left operand to the op
- op_rhs  output  OPERAND_WIDTH  right operand to the op
- op_result  input  OPERAND_WIDTH  result from the op
- busy  output  1  high in every state except RX_LHS with byte index 0

Behaviour:
- Reset (rst low, async): state IDLE, byte index 0, latency counter 0, op_lhs=0, op_rhs=0, captured result=0, rx_ready=0, tx_valid=0, tx_data=0, busy=1.
- States and transitions:
  - IDLE: one cycle after reset release, then RX_LHS.
  - RX_LHS: rx_ready=1. Each rx_valid&&rx_ready cycle writes byte k into lhs shadow bits [8k+7:8k]. After byte BYTES-1, index resets to 0 and the FSM goes to RX_RHS.
  - RX_RHS: same handling into the rhs shadow. On the last byte, op_lhs/op_rhs load from the shadows on that same edge and the FSM goes to EVAL.
  - EVAL: lasts RESULT_LATENCY+1 cycles, counted by the latency counter. On the last EVAL cycle the edge captures op_result; FSM then goes to TX.
  - TX: tx_valid=1. tx_data = captured result byte k, least-significant byte first. It advances only on tx_valid&&tx_ready. After byte BYTES-1 is accepted, the FSM goes to RX_LHS.
- Byte order is LSB first for lhs, rhs and result.
- Width rules:
  - Received bits above OPERAND_WIDTH-1 in the last byte are discarded.
  - Transmitted bits above OPERAND_WIDTH-1 in the last byte are 0.
- rx_ready is 0 outside RX_LHS/RX_RHS. Bytes presented then are not consumed.
- tx_data is stable while tx_valid && !tx_ready; tx_valid never drops before acceptance.
- op_lhs/op_rhs change only on the final RX_RHS byte edge. They hold their values through TX and during reception of the next frame.
- Back-to-back: the first byte of the next frame can be accepted the cycle after the last TX byte is accepted.
- flush:
  - Highest priority below rst. Next state is RX_LHS with byte index 0 and latency counter 0.
  - tx_valid drops next cycle. op_lhs/op_rhs and the captured result are unchanged; the partial shadow contents are don't-care.
  - A byte accepted in the flush cycle is discarded.
- rst asserted mid-frame: immediate return to reset values. No partial frame survives.
- Minimum frame latency, last rhs byte accepted to first tx_valid: RESULT_LATENCY+2 cycles.

Test Plan:
- Bench uses OPERAND_WIDTH=12, RESULT_LATENCY=0, and op = lhs^rhs.
- Basic frame: send 0x34,0x12,0xFF,0x0F with rx_valid always high -> op_lhs=0x234, op_rhs=0xFFF; tx bytes 0xCB then 0x0D; first tx_valid 2 cycles after the last rx byte.
- Backpressure: same frame with tx_ready low for 5 cycles during the first byte -> tx_data holds 0xCB and tx_valid stays high; then 0x0D; no byte lost or duplicated.
- Latency: RESULT_LATENCY=3, op result registered through 3 flops, lhs=0x0F0, rhs=0x00F -> captured result 0x0FF; first tx_valid exactly 5 cycles after the last rx byte.
- flush: assert flush after 3 rx bytes -> next cycle state is RX_LHS and op_lhs/op_rhs keep prior values. A following full frame 0x01,0x00,0x01,0x00 -> tx 0x00,0x00.
- Async reset: drop rst during TX byte 1 -> tx_valid, rx_ready, op_lhs and op_rhs go to 0 without a clock edge. After release, one IDLE cycle, then rx_ready=1.
- Idle stream: rx_valid pulses while in EVAL/TX -> rx_ready=0, bytes not consumed, result unaffected.
